// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter:
//   - arb_state_e : FSM states (ARB_IDLE, ARB_RESP_CORE, ARB_RESP_DBG)
//   - ARB_ID_*    : requester IDs (core = 0, debug/loader = 1)
//   - arb_pick    : winner selection helper
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_RESP_CORE = 2'd1,
    ARB_RESP_DBG  = 2'd2
  } arb_state_e;

  localparam logic ARB_ID_CORE = 1'b0;
  localparam logic ARB_ID_DBG  = 1'b1;

  // A lone requester always wins; on contention the debug port wins only
  // when prefer_dbg is set.
  function automatic logic arb_pick(input logic a_core_req,
                                    input logic a_dbg_req,
                                    input logic a_prefer_dbg);
    return (a_dbg_req && (!a_core_req || a_prefer_dbg)) ? ARB_ID_DBG : ARB_ID_CORE;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Arbitrates the core load/store port and the debug/loader port onto a
// single data-memory port. One access granted per cycle; the response
// (rvalid/rdata) follows the grant by exactly one cycle.
//
// Ports:
//   clk, rst                          clock, async active-high reset
//   core_req/we/be/addr/wdata   (in)  core request and payload
//   core_gnt/rvalid/rdata       (out) core grant, response valid, load data
//   dbg_*                             same as core_* for the debug port
//   mem_en/we/be/addr/wdata     (out) memory strobe and forwarded payload
//   mem_rdata                   (in)  memory read data, one cycle after mem_en
//
// Build option: define DMEM_ARB_RR_EN for round-robin arbitration on
// contention; otherwise the core port has fixed priority.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [DATA_W/8-1:0]   core_be,
  input  logic [ADDR_W-1:0]     core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_W-1:0]     core_rdata,

  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [DATA_W/8-1:0]   dbg_be,
  input  logic [ADDR_W-1:0]     dbg_addr,
  input  logic [DATA_W-1:0]     dbg_wdata,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_W-1:0]     dbg_rdata,

  output logic                  mem_en,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  logic       r_resp_we;     // owed response is for a store (rdata forced to 0)
  logic       w_grant;
  logic       w_winner;
  logic       w_winner_we;
  logic       w_prefer_dbg;

  // Grant is combinational; gating with rst keeps every output at 0
  // for the whole time reset is asserted.
  assign w_grant = (core_req | dbg_req) & ~rst;

`ifdef DMEM_ARB_RR_EN
  logic r_last_winner;

  // Reset to "debug last" so the core wins the first contended cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_winner <= ARB_ID_DBG;
    end else if (w_grant) begin
      r_last_winner <= w_winner;
    end
  end

  assign w_prefer_dbg = (r_last_winner == ARB_ID_CORE);
`else
  assign w_prefer_dbg = 1'b0;
`endif

  assign w_winner    = arb_pick(core_req, dbg_req, w_prefer_dbg);
  assign w_winner_we = (w_winner == ARB_ID_DBG) ? dbg_we : core_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ARB_IDLE;
      r_resp_we <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_resp_we <= w_grant & w_winner_we;
    end
  end

  always_comb begin
    w_state_next = ARB_IDLE;
    if (w_grant) begin
      w_state_next = (w_winner == ARB_ID_DBG) ? ARB_RESP_DBG : ARB_RESP_CORE;
    end
  end

  always_comb begin
    core_gnt    = 1'b0;
    core_rvalid = 1'b0;
    core_rdata  = '0;
    dbg_gnt     = 1'b0;
    dbg_rvalid  = 1'b0;
    dbg_rdata   = '0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_be      = '0;
    mem_addr    = '0;
    mem_wdata   = '0;

    if (w_grant) begin
      mem_en = 1'b1;
      if (w_winner == ARB_ID_DBG) begin
        dbg_gnt   = 1'b1;
        mem_we    = dbg_we;
        mem_be    = dbg_be;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end else begin
        core_gnt  = 1'b1;
        mem_we    = core_we;
        mem_be    = core_be;
        mem_addr  = core_addr;
        mem_wdata = core_wdata;
      end
    end

    // Response path is independent of the grant path, so a new access can
    // be granted in the same cycle a previous one is answered.
    case (r_state)
      ARB_RESP_CORE: begin
        core_rvalid = 1'b1;
        if (!r_resp_we) core_rdata = mem_rdata;
      end
      ARB_RESP_DBG: begin
        dbg_rvalid = 1'b1;
        if (!r_resp_we) dbg_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. A behavioural memory sits on the
// mem_* port; expected responses are pushed per port when a grant is
// expected and popped when the matching rvalid appears.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          core_req = 1'b0, core_we = 1'b0;
  logic [3:0]    core_be = '0;
  logic [AW-1:0] core_addr = '0;
  logic [DW-1:0] core_wdata = '0;
  logic          core_gnt, core_rvalid;
  logic [DW-1:0] core_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [3:0]    dbg_be = '0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_be(core_be),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_be(dbg_be),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int unsigned cyc = 0;

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   cyc;
  } exp_t;

  exp_t        core_q[$];
  exp_t        dbg_q[$];
  exp_t        e_mon;
  logic [DW-1:0] mem [64];
  logic [DW-1:0] ref_mem [64];
  logic        model_last = ARB_ID_DBG;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural memory: read data registered, valid the cycle after mem_en.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem[mem_addr[5:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem[mem_addr[5:0]];
      end
    end
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (core_rvalid && dbg_rvalid) begin
        checks++; failures++;
        $display("FAIL dual_rvalid core_rvalid=%0b dbg_rvalid=%0b exp=only one", core_rvalid, dbg_rvalid);
      end
      checks++;
      if (core_rvalid) begin
        if (core_q.size() == 0) begin
          failures++;
          $display("FAIL core_unexp_rvalid got rdata=%h exp=no response", core_rdata);
        end else begin
          e_mon = core_q.pop_front();
          if (core_rdata !== e_mon.data || cyc !== e_mon.cyc) begin
            failures++;
            $display("FAIL core_resp got rdata=%h cyc=%0d exp rdata=%h cyc=%0d",
                     core_rdata, cyc, e_mon.data, e_mon.cyc);
          end
        end
      end else if (core_rdata !== '0) begin
        failures++;
        $display("FAIL core_rdata_idle got=%h exp=0", core_rdata);
      end
      checks++;
      if (dbg_rvalid) begin
        if (dbg_q.size() == 0) begin
          failures++;
          $display("FAIL dbg_unexp_rvalid got rdata=%h exp=no response", dbg_rdata);
        end else begin
          e_mon = dbg_q.pop_front();
          if (dbg_rdata !== e_mon.data || cyc !== e_mon.cyc) begin
            failures++;
            $display("FAIL dbg_resp got rdata=%h cyc=%0d exp rdata=%h cyc=%0d",
                     dbg_rdata, cyc, e_mon.data, e_mon.cyc);
          end
        end
      end else if (dbg_rdata !== '0) begin
        failures++;
        $display("FAIL dbg_rdata_idle got=%h exp=0", dbg_rdata);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_core(input logic req, input logic we, input logic [3:0] be,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    core_req = req; core_we = we; core_be = be; core_addr = addr; core_wdata = wdata;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [3:0] be,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    dbg_req = req; dbg_we = we; dbg_be = be; dbg_addr = addr; dbg_wdata = wdata;
  endtask

  // Reference arbitration model (call only when at least one port requests).
  function automatic logic predict();
    if (core_req && dbg_req) begin
`ifdef DMEM_ARB_RR_EN
      return (model_last == ARB_ID_CORE) ? ARB_ID_DBG : ARB_ID_CORE;
`else
      return ARB_ID_CORE;
`endif
    end
    return core_req ? ARB_ID_CORE : ARB_ID_DBG;
  endfunction

  // Records the expected response of the access granted to port `id`.
  task automatic expect_grant(input logic id);
    logic          we;
    logic [3:0]    be;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    exp_t          e;
    we = (id == ARB_ID_DBG) ? dbg_we    : core_we;
    be = (id == ARB_ID_DBG) ? dbg_be    : core_be;
    a  = (id == ARB_ID_DBG) ? dbg_addr  : core_addr;
    wd = (id == ARB_ID_DBG) ? dbg_wdata : core_wdata;
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a[5:0]][b*8 +: 8] = wd[b*8 +: 8];
      e.data = '0;
    end else begin
      e.data = ref_mem[a[5:0]];
    end
    e.cyc = cyc + 1;
    if (id == ARB_ID_DBG) dbg_q.push_back(e);
    else core_q.push_back(e);
    model_last = id;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    model_last = ARB_ID_DBG;
    core_q.delete();
    dbg_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_core(1'b1, 1'b1, 4'hf, 32'h7, 32'hcafef00d);
    drive_dbg(1'b1, 1'b0, 4'hf, 32'h9, 32'h0);
    tick();
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_gnt, mem_en} !== 3'b000) begin
      failures++;
      $display("FAIL reset_gnt got=%b exp=000", {core_gnt, dbg_gnt, mem_en});
    end
    checks++;
    if ({mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_mem_payload got be=%h addr=%h wdata=%h exp=0", mem_be, mem_addr, mem_wdata);
    end
    checks++;
    if ({core_rvalid, dbg_rvalid, core_rdata, dbg_rdata} !== '0) begin
      failures++;
      $display("FAIL reset_resp got rv=%b%b exp=00 and rdata 0", core_rvalid, dbg_rvalid);
    end
    checks++;
    if (dut.r_state !== ARB_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", dut.r_state, ARB_IDLE);
    end
    drive_core(1'b0, 1'b0, 4'h0, '0, '0);
    drive_dbg(1'b0, 1'b0, 4'h0, '0, '0);
    tick();
    rst = 1'b0;
    model_last = ARB_ID_DBG;
    tick();
  endtask

  task automatic test_single_load();
    drive_core(1'b1, 1'b0, 4'hf, 32'd1, 32'h0);
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_gnt, mem_en, mem_we} !== 4'b1010 || mem_addr !== 32'd1) begin
      failures++;
      $display("FAIL single_load_grant got gnt=%b%b en=%b we=%b addr=%h exp 1 0 1 0 addr=1",
               core_gnt, dbg_gnt, mem_en, mem_we, mem_addr);
    end
    expect_grant(ARB_ID_CORE);
    tick();
    // Payload left non-zero with req low: memory outputs must still read 0.
    drive_core(1'b0, 1'b1, 4'hf, 32'd1, 32'hdeadbeef);
    @(negedge clk);
    checks++;
    if ({mem_en, mem_we, mem_be, mem_addr, mem_wdata} !== '0) begin
      failures++;
      $display("FAIL idle_mem_zero got en=%b we=%b be=%h addr=%h wdata=%h exp=0",
               mem_en, mem_we, mem_be, mem_addr, mem_wdata);
    end
    tick();
  endtask

  task automatic test_store_then_dbg_load();
    drive_core(1'b1, 1'b1, 4'hf, 32'd13, 32'h12345678);
    @(negedge clk);
    checks++;
    if (core_gnt !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'hf || mem_wdata !== 32'h12345678) begin
      failures++;
      $display("FAIL core_store got gnt=%b we=%b be=%h wdata=%h exp 1 1 f 12345678",
               core_gnt, mem_we, mem_be, mem_wdata);
    end
    expect_grant(ARB_ID_CORE);
    tick();
    drive_core(1'b0, 1'b0, 4'h0, '0, '0);
    drive_dbg(1'b1, 1'b0, 4'hf, 32'd13, 32'h0);
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_gnt} !== 2'b01 || mem_addr !== 32'd13 || core_rvalid !== 1'b1 || core_rdata !== '0) begin
      failures++;
      $display("FAIL dbg_load_after_store got gnt=%b%b addr=%h core_rv=%b core_rd=%h exp 01 d 1 0",
               core_gnt, dbg_gnt, mem_addr, core_rvalid, core_rdata);
    end
    expect_grant(ARB_ID_DBG);
    tick();
    drive_dbg(1'b0, 1'b0, 4'h0, '0, '0);
    drive_core(1'b1, 1'b1, 4'b0101, 32'd14, 32'haabbccdd);
    @(negedge clk);
    checks++;
    if (core_gnt !== 1'b1 || mem_be !== 4'b0101) begin
      failures++;
      $display("FAIL partial_store got gnt=%b be=%b exp 1 0101", core_gnt, mem_be);
    end
    expect_grant(ARB_ID_CORE);
    tick();
    drive_core(1'b1, 1'b0, 4'hf, 32'd14, 32'h0);
    @(negedge clk);
    expect_grant(ARB_ID_CORE);
    tick();
    drive_core(1'b0, 1'b0, 4'h0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_contention();
    logic [3:0] seq;
`ifdef DMEM_ARB_RR_EN
    seq = 4'b1010;   // bit i = winner of cycle i (1 = dbg): C,D,C,D
`else
    seq = 4'b0000;   // C,C,C,C
`endif
    apply_reset();
    drive_core(1'b1, 1'b0, 4'hf, 32'd2, 32'h0);
    drive_dbg(1'b1, 1'b0, 4'hf, 32'd3, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (core_gnt !== !seq[i] || dbg_gnt !== seq[i]) begin
        failures++;
        $display("FAIL contention_c%0d got gnt=%b%b exp=%b%b", i, core_gnt, dbg_gnt, !seq[i], seq[i]);
      end
      expect_grant(seq[i]);
      tick();
    end
    drive_core(1'b0, 1'b0, 4'h0, '0, '0);
    drive_dbg(1'b0, 1'b0, 4'h0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_dbg_wait();
    logic w;
    drive_core(1'b1, 1'b0, 4'hf, 32'd4, 32'h0);
    drive_dbg(1'b1, 1'b0, 4'hf, 32'd5, 32'h0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      w = predict();
      checks++;
      if (dbg_gnt !== w || core_gnt !== !w || mem_addr !== (w ? 32'd5 : 32'd4)) begin
        failures++;
        $display("FAIL dbg_wait_c%0d got gnt=%b%b addr=%h exp gnt=%b%b", i, core_gnt, dbg_gnt, mem_addr, !w, w);
      end
      expect_grant(w);
      tick();
    end
    drive_core(1'b0, 1'b0, 4'h0, '0, '0);
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_gnt} !== 2'b01 || mem_addr !== 32'd5) begin
      failures++;
      $display("FAIL dbg_after_core got gnt=%b%b addr=%h exp 01 addr=5", core_gnt, dbg_gnt, mem_addr);
    end
    expect_grant(ARB_ID_DBG);
    tick();
    drive_dbg(1'b0, 1'b0, 4'h0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      drive_core(1'b1, 1'b0, 4'hf, i, 32'h0);
      @(negedge clk);
      checks++;
      if (core_gnt !== 1'b1 || mem_addr !== i) begin
        failures++;
        $display("FAIL b2b_c%0d got gnt=%b addr=%h exp 1 addr=%0d", i, core_gnt, mem_addr, i);
      end
      expect_grant(ARB_ID_CORE);
      tick();
    end
    drive_core(1'b0, 1'b0, 4'h0, '0, '0);
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    drive_core(1'b1, 1'b0, 4'hf, 32'd5, 32'h0);
    @(negedge clk);
    checks++;
    if (core_gnt !== 1'b1) begin
      failures++;
      $display("FAIL midflight_grant got=%b exp=1", core_gnt);
    end
    expect_grant(ARB_ID_CORE);
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({core_rvalid, dbg_rvalid, core_gnt, dbg_gnt, mem_en} !== 5'b0 ||
        core_rdata !== '0 || mem_addr !== '0) begin
      failures++;
      $display("FAIL midflight_outputs got rv=%b%b gnt=%b%b en=%b rd=%h exp all 0",
               core_rvalid, dbg_rvalid, core_gnt, dbg_gnt, mem_en, core_rdata);
    end
    checks++;
    if (dut.r_state !== ARB_IDLE) begin
      failures++;
      $display("FAIL midflight_state got=%0d exp=%0d", dut.r_state, ARB_IDLE);
    end
    core_q.delete();
    dbg_q.delete();
    drive_core(1'b0, 1'b0, 4'h0, '0, '0);
    tick();
    rst = 1'b0;
    model_last = ARB_ID_DBG;
    drive_dbg(1'b1, 1'b0, 4'hf, 32'd1, 32'h0);
    @(negedge clk);
    checks++;
    if (dbg_gnt !== 1'b1 || core_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_grant got dbg_gnt=%b core_rv=%b exp 1 0", dbg_gnt, core_rvalid);
    end
    expect_grant(ARB_ID_DBG);
    tick();
    drive_dbg(1'b0, 1'b0, 4'h0, '0, '0);
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[1] = 32'hff04a1c0;
    ref_mem[1] = 32'hff04a1c0;

    test_reset();
    test_single_load();
    test_store_then_dbg_load();
    test_contention();
    test_dbg_wait();
    test_back_to_back();
    test_reset_midflight();

    checks++;
    if (core_q.size() != 0 || dbg_q.size() != 0) begin
      failures++;
      $display("FAIL missing_responses got pending core=%0d dbg=%0d exp=0 0", core_q.size(), dbg_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
